// File: rtl/buffered_rr_switch_pkg.sv
// Shared helpers for the buffered round-robin switch: index-width functions.
package buffered_switch_pkg;

  // Width of an output index; never narrower than one bit.
  function automatic int dest_w(input int n_out);
    return ($clog2(n_out) > 1) ? $clog2(n_out) : 1;
  endfunction

  // Width of an input (source) index; never narrower than one bit.
  function automatic int src_w(input int n_in);
    return ($clog2(n_in) > 1) ? $clog2(n_in) : 1;
  endfunction

endpackage

// File: rtl/buffered_rr_switch_fifo.sv
// First-word-fall-through FIFO: head is valid whenever empty is low.
// No bypass: a push into an empty FIFO shows up on dout one cycle later.
module sync_fifo_fwft
  import buffered_switch_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push, w_pop;

  // Guard against overflow/underflow so callers cannot corrupt pointers.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  assign full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/buffered_rr_switch.sv
// Input-buffered crossbar: per-input FWFT FIFOs, per-output round-robin
// arbiters and registered valid/ready outputs tagged with the source input.
module buffered_rr_switch
  import buffered_switch_pkg::*;
#(
  parameter  int DATA_WIDTH      = 8,
  parameter  int INPUT_QTY       = 2,
  parameter  int OUTPUT_QTY      = 2,
  parameter  int FIFO_DEPTH_LOG2 = 2,
  localparam int DEST_W          = dest_w(OUTPUT_QTY),
  localparam int SRC_W           = src_w(INPUT_QTY)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [INPUT_QTY-1:0]                  data_in_valid,
  output logic [INPUT_QTY-1:0]                  data_in_ready,
  input  logic [INPUT_QTY-1:0][DATA_WIDTH-1:0]  data_in,
  input  logic [INPUT_QTY-1:0][DEST_W-1:0]      data_in_destination,
  output logic [OUTPUT_QTY-1:0]                 data_out_valid,
  input  logic [OUTPUT_QTY-1:0]                 data_out_ready,
  output logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0] data_out,
  output logic [OUTPUT_QTY-1:0][SRC_W-1:0]      data_out_source,
  output logic [INPUT_QTY-1:0]                  drop_pulse
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_W-1:0]     destination;
  } fifo_entry_t;

  fifo_entry_t [INPUT_QTY-1:0]                 w_din, w_head;
  logic [INPUT_QTY-1:0]                        w_full, w_empty, w_push, w_pop;
  logic [INPUT_QTY-1:0]                        w_dst_ok, w_drop;
  logic [OUTPUT_QTY-1:0][INPUT_QTY-1:0]        w_req, w_pop_by_out;

  // Ready depends on occupancy only; a full FIFO never accepts even if popping.
  assign data_in_ready = ~w_full;
  assign w_push        = data_in_valid & ~w_full;

  for (genvar i = 0; i < INPUT_QTY; i++) begin : g_in
    assign w_din[i] = '{data: data_in[i], destination: data_in_destination[i]};

    sync_fifo_fwft #(
      .WIDTH      ($bits(fifo_entry_t)),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push[i]),
      .din   (w_din[i]),
      .pop   (w_pop[i]),
      .dout  (w_head[i]),
      .full  (w_full[i]),
      .empty (w_empty[i])
    );

    // Each head addresses exactly one output, so requests never conflict.
    for (genvar o = 0; o < OUTPUT_QTY; o++) begin : g_req
      assign w_req[o][i] = ~w_empty[i] && (w_head[i].destination == DEST_W'(o));
    end
  end

  // A head matching no output is discarded; pops come from grants or drops.
  always_comb begin
    w_dst_ok = '0;
    w_pop    = '0;
    for (int o = 0; o < OUTPUT_QTY; o++) begin
      w_dst_ok = w_dst_ok | w_req[o];
      w_pop    = w_pop | w_pop_by_out[o];
    end
    w_drop = ~w_empty & ~w_dst_ok;
    w_pop  = w_pop | w_drop;
  end

  assign drop_pulse = w_drop;

  for (genvar o = 0; o < OUTPUT_QTY; o++) begin : g_out
    logic [SRC_W-1:0]      r_rr, r_src, w_gnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_vld, w_any, w_load;

    // Round-robin search: first requester at or after r_rr, modulo INPUT_QTY.
    // Scanning from the far end lets the nearest requester win.
    always_comb begin
      int               j;
      logic [SRC_W-1:0] w_idx;
      j     = 0;
      w_idx = '0;
      w_gnt = '0;
      w_any = 1'b0;
      for (int k = INPUT_QTY-1; k >= 0; k--) begin
        j = int'(r_rr) + k;
        if (j >= INPUT_QTY) j = j - INPUT_QTY;
        w_idx = SRC_W'(j);
        if (w_req[o][w_idx]) begin
          w_any = 1'b1;
          w_gnt = w_idx;
        end
      end
    end

    assign w_load          = w_any && (!r_vld || data_out_ready[o]);
    assign w_pop_by_out[o] = w_load ? (INPUT_QTY'(1) << w_gnt) : '0;

    // Output register: load on grant, hold under backpressure, clear when drained.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_vld  <= 1'b0;
        r_data <= '0;
        r_src  <= '0;
        r_rr   <= '0;
      end else if (w_load) begin
        r_vld  <= 1'b1;
        r_data <= w_head[w_gnt].data;
        r_src  <= w_gnt;
        r_rr   <= (w_gnt == SRC_W'(INPUT_QTY-1)) ? '0 : w_gnt + 1'b1;
      end else if (data_out_ready[o]) begin
        r_vld  <= 1'b0;
      end
    end

    assign data_out_valid[o]  = r_vld;
    assign data_out[o]        = r_data;
    assign data_out_source[o] = r_src;
  end

endmodule

// File: tb/tb_buffered_rr_switch.sv
// Directed bench for buffered_rr_switch with 2 inputs, 3 outputs, depth 4.
module tb_buffered_rr_switch;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       din_v, din_rdy, drop;
  logic [1:0][7:0]  din;
  logic [1:0][1:0]  din_dst;
  logic [2:0]       dout_v, dout_rdy;
  logic [2:0][7:0]  dout;
  logic [2:0][0:0]  dout_src;

  int n_vec = 0;
  int n_err = 0;

  buffered_rr_switch #(
    .DATA_WIDTH      (8),
    .INPUT_QTY       (2),
    .OUTPUT_QTY      (3),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .data_in_valid       (din_v),
    .data_in_ready       (din_rdy),
    .data_in             (din),
    .data_in_destination (din_dst),
    .data_out_valid      (dout_v),
    .data_out_ready      (dout_rdy),
    .data_out            (dout),
    .data_out_source     (dout_src),
    .drop_pulse          (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_v = '0;
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_d [8];
    logic       exp_s [8];
    int         idx;

    reset    = 1'b0;
    din_v    = '0;
    din      = '0;
    din_dst  = '0;
    dout_rdy = 3'b111;

    // reset state
    #3;
    chk("rst valid", 32'(dout_v), 32'h0);
    chk("rst data", 32'(dout), 32'h0);
    chk("rst src", 32'(dout_src), 32'h0);
    chk("rst drop", 32'(drop), 32'h0);
    tick();
    reset = 1'b1;
    chk("rst ready", 32'(din_rdy), 32'h3);

    // single word in0 -> out1
    din_v = 2'b01; din[0] = 8'hA5; din_dst[0] = 2'd1;
    tick();
    din_v = '0;
    chk("t1 early", 32'(dout_v), 32'h0);
    tick();
    chk("t1 valid", 32'(dout_v), 32'h2);
    chk("t1 data", 32'(dout[1]), 32'hA5);
    chk("t1 src", 32'(dout_src[1]), 32'h0);
    tick();
    chk("t1 release", 32'(dout_v), 32'h0);

    // contention: both inputs stream 4 words to out0, grants alternate
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_d[2*k]   = 8'h10 + 8'(k); exp_s[2*k]   = 1'b0;
      exp_d[2*k+1] = 8'h20 + 8'(k); exp_s[2*k+1] = 1'b1;
    end
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        din_v = 2'b11;
        din[0] = 8'h10 + 8'(c); din[1] = 8'h20 + 8'(c);
        din_dst[0] = 2'd0; din_dst[1] = 2'd0;
      end else begin
        din_v = '0;
      end
      tick();
      if (c >= 1 && c <= 8) begin
        chk("t2 valid", 32'(dout_v[0]), 32'h1);
        chk("t2 data", 32'(dout[0]), 32'(exp_d[idx]));
        chk("t2 src", 32'(dout_src[0]), 32'(exp_s[idx]));
        idx++;
      end else begin
        chk("t2 idle", 32'(dout_v[0]), 32'h0);
      end
    end

    // backpressure: 1 word in output register + 4 in FIFO
    do_reset();
    dout_rdy = 3'b110;
    for (int k = 0; k < 5; k++) begin
      din_v = 2'b01; din[0] = 8'h30 + 8'(k); din_dst[0] = 2'd0;
      tick();
      if (k == 3) chk("t3 ready4", 32'(din_rdy[0]), 32'h1);
    end
    din_v = '0;
    chk("t3 full", 32'(din_rdy[0]), 32'h0);
    tick();
    chk("t3 hold v", 32'(dout_v[0]), 32'h1);
    chk("t3 hold d", 32'(dout[0]), 32'h30);
    dout_rdy = 3'b111;
    for (int k = 0; k < 5; k++) begin
      chk("t3 drain v", 32'(dout_v[0]), 32'h1);
      chk("t3 drain d", 32'(dout[0]), 32'h30 + 32'(k));
      tick();
    end
    chk("t3 empty", 32'(dout_v[0]), 32'h0);
    chk("t3 ready", 32'(din_rdy[0]), 32'h1);

    // invalid destination on in1, then a valid word to out2
    do_reset();
    din_v = 2'b10; din[1] = 8'h77; din_dst[1] = 2'd3;
    tick();
    chk("t4 drop", 32'(drop), 32'h2);
    chk("t4 no out", 32'(dout_v), 32'h0);
    din[1] = 8'h5C; din_dst[1] = 2'd2;
    tick();
    din_v = '0;
    chk("t4 drop end", 32'(drop), 32'h0);
    chk("t4 no out2", 32'(dout_v), 32'h0);
    tick();
    chk("t4 fwd v", 32'(dout_v), 32'h4);
    chk("t4 fwd d", 32'(dout[2]), 32'h5C);
    chk("t4 fwd s", 32'(dout_src[2]), 32'h1);

    // head-of-line isolation: in0 stalled on out0, in1 proceeds to out1
    do_reset();
    dout_rdy = 3'b110;
    din_v = 2'b01; din[0] = 8'h41; din_dst[0] = 2'd0;
    tick();
    din[0] = 8'h42;
    tick();
    din_v = 2'b10; din[1] = 8'h99; din_dst[1] = 2'd1;
    tick();
    din_v = '0;
    chk("t5 early", 32'(dout_v[1]), 32'h0);
    tick();
    chk("t5 out1 v", 32'(dout_v[1]), 32'h1);
    chk("t5 out1 d", 32'(dout[1]), 32'h99);
    chk("t5 out1 s", 32'(dout_src[1]), 32'h1);
    chk("t5 out0 v", 32'(dout_v[0]), 32'h1);
    chk("t5 out0 d", 32'(dout[0]), 32'h41);
    dout_rdy = 3'b111;
    tick();
    chk("t5 out0 next", 32'(dout[0]), 32'h42);
    chk("t5 out0 src", 32'(dout_src[0]), 32'h0);

    // async reset with FIFOs partly full
    do_reset();
    dout_rdy = 3'b000;
    for (int k = 0; k < 2; k++) begin
      din_v = 2'b11;
      din[0] = 8'h50 + 8'(k); din[1] = 8'h60 + 8'(k);
      din_dst[0] = 2'd0; din_dst[1] = 2'd0;
      tick();
    end
    din_v = '0;
    chk("t6 pre v", 32'(dout_v[0]), 32'h1);
    #4;
    reset = 1'b0;
    #1;
    chk("t6 rst v", 32'(dout_v), 32'h0);
    chk("t6 rst d", 32'(dout), 32'h0);
    chk("t6 rst s", 32'(dout_src), 32'h0);
    tick();
    reset = 1'b1;
    dout_rdy = 3'b111;
    chk("t6 ready", 32'(din_rdy), 32'h3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6 no stale", 32'(dout_v), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
